// File: rtl/coverfloat32_reporter.sv
// In-order issue/completion pairing buffer that emits DUT-side coverfloat32 records.
// Optional legality flag (err_illegal) is built when COVERFLOAT_LEGAL_CHECK_EN is defined.
module coverfloat32_reporter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] issue_op,
    input  logic [31:0] issue_rm,
    input  logic [31:0] issue_enable,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [31:0] issue_c,
    input  logic        cmpl_valid,
    input  logic [31:0] cmpl_result,
    input  logic [4:0]  cmpl_flags,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_op,
    output logic [31:0] rec_rm,
    output logic [31:0] rec_enable,
    output logic [31:0] rec_exc,
    output logic [31:0] rec_a,
    output logic [31:0] rec_b,
    output logic [31:0] rec_c,
    output logic [31:0] rec_result,
    output logic        err_orphan
`ifdef COVERFLOAT_LEGAL_CHECK_EN
    ,
    output logic        err_illegal
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cmpl_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   pend;
    logic [DEPTH-1:0] done;

    logic [31:0] op_mem  [DEPTH];
    logic [31:0] rm_mem  [DEPTH];
    logic [31:0] en_mem  [DEPTH];
    logic [31:0] a_mem   [DEPTH];
    logic [31:0] b_mem   [DEPTH];
    logic [31:0] c_mem   [DEPTH];
    logic [31:0] res_mem [DEPTH];
    logic [31:0] exc_mem [DEPTH];

    logic issue_fire;
    logic cmpl_fire;
    logic pop;

    assign issue_ready = (count < FULL);
    assign issue_fire  = issue_valid && issue_ready;
    // pend is sampled before this cycle's issue, so a same-cycle issue cannot absorb a completion
    assign cmpl_fire   = cmpl_valid && (pend != '0);
    assign rec_valid   = done[rd_ptr];
    assign pop         = rec_valid && rec_ready;

    assign rec_op     = op_mem[rd_ptr];
    assign rec_rm     = rm_mem[rd_ptr];
    assign rec_enable = en_mem[rd_ptr];
    assign rec_a      = a_mem[rd_ptr];
    assign rec_b      = b_mem[rd_ptr];
    assign rec_c      = c_mem[rd_ptr];
    assign rec_result = res_mem[rd_ptr];
    assign rec_exc    = exc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            cmpl_ptr   <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend       <= '0;
            done       <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue_fire) begin
                wr_ptr       <= wr_ptr + AW'(1);
                done[wr_ptr] <= 1'b0;
            end
            if (cmpl_fire) begin
                cmpl_ptr       <= cmpl_ptr + AW'(1);
                done[cmpl_ptr] <= 1'b1;
            end else if (cmpl_valid) begin
                err_orphan <= 1'b1;
            end
            // popped entries are cleared so a wrapped rd never sees a stale done bit
            if (pop) begin
                rd_ptr       <= rd_ptr + AW'(1);
                done[rd_ptr] <= 1'b0;
            end
            if (issue_fire && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!issue_fire && pop) begin
                count <= count - (AW + 1)'(1);
            end
            if (issue_fire && !cmpl_fire) begin
                pend <= pend + (AW + 1)'(1);
            end else if (!issue_fire && cmpl_fire) begin
                pend <= pend - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            op_mem[wr_ptr] <= issue_op;
            rm_mem[wr_ptr] <= issue_rm;
            en_mem[wr_ptr] <= issue_enable;
            a_mem[wr_ptr]  <= issue_a;
            b_mem[wr_ptr]  <= issue_b;
            c_mem[wr_ptr]  <= issue_c;
        end
        if (cmpl_fire) begin
            res_mem[cmpl_ptr] <= cmpl_result;
            exc_mem[cmpl_ptr] <= {27'b0, cmpl_flags};
        end
    end

`ifdef COVERFLOAT_LEGAL_CHECK_EN
    logic op_ok;
    logic rm_ok;

    always_comb begin
        op_ok = (issue_op >= 32'd1) && (issue_op <= 32'd13);
        rm_ok = (issue_rm <= 32'd4) || (issue_rm == 32'd6);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_illegal <= 1'b0;
        end else if (issue_fire && !(op_ok && rm_ok)) begin
            err_illegal <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_coverfloat32_reporter.sv
// Self-checking bench for coverfloat32_reporter: directed table, reset sequences, random vs queue model.
module tb_coverfloat32_reporter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_op, issue_rm, issue_enable, issue_a, issue_b, issue_c;
    logic        cmpl_valid;
    logic [31:0] cmpl_result;
    logic [4:0]  cmpl_flags;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_op, rec_rm, rec_enable, rec_exc, rec_a, rec_b, rec_c, rec_result;
    logic        err_orphan;
`ifdef COVERFLOAT_LEGAL_CHECK_EN
    logic        err_illegal;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    coverfloat32_reporter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rm(issue_rm), .issue_enable(issue_enable),
        .issue_a(issue_a), .issue_b(issue_b), .issue_c(issue_c),
        .cmpl_valid(cmpl_valid), .cmpl_result(cmpl_result), .cmpl_flags(cmpl_flags),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_op(rec_op), .rec_rm(rec_rm), .rec_enable(rec_enable), .rec_exc(rec_exc),
        .rec_a(rec_a), .rec_b(rec_b), .rec_c(rec_c), .rec_result(rec_result),
        .err_orphan(err_orphan)
`ifdef COVERFLOAT_LEGAL_CHECK_EN
        , .err_illegal(err_illegal)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_op = '0; issue_rm = '0; issue_enable = '0;
        issue_a = '0; issue_b = '0; issue_c = '0;
        cmpl_valid = 1'b0; cmpl_result = '0; cmpl_flags = '0; rec_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          iv;
        logic [31:0] op, a, b;
        bit          cv;
        logic [31:0] res;
        logic [4:0]  fl;
        bit          rr;
        bit          e_ir, e_rv, e_orph;
        logic [31:0] e_op, e_res, e_exc;
    } step_t;

    step_t tbl[22];

    function automatic step_t mk(bit iv, logic [31:0] op, logic [31:0] a, logic [31:0] b,
                                 bit cv, logic [31:0] res, logic [4:0] fl, bit rr,
                                 bit e_ir, bit e_rv, bit e_orph,
                                 logic [31:0] e_op, logic [31:0] e_res, logic [31:0] e_exc);
        step_t s;
        s.iv = iv; s.op = op; s.a = a; s.b = b; s.cv = cv; s.res = res; s.fl = fl; s.rr = rr;
        s.e_ir = e_ir; s.e_rv = e_rv; s.e_orph = e_orph;
        s.e_op = e_op; s.e_res = e_res; s.e_exc = e_exc;
        return s;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] op, rm, en, a, b, c, res, exc;
    } rec_t;

    rec_t        mq[$];
    int unsigned mdone = 0;
    bit          morph = 0;
    bit          mill = 0;

    task automatic model_update();
        bit          rdy;
        bit          vld;
        int unsigned npend;
        rec_t        t;
        if (reset) begin
            mq.delete(); mdone = 0; morph = 0; mill = 0;
        end else begin
            rdy   = (mq.size() < DEPTH);
            vld   = (mdone > 0);
            npend = mq.size() - mdone;
            if (cmpl_valid) begin
                if (npend > 0) begin
                    t = mq[mdone];
                    t.res = cmpl_result;
                    t.exc = {27'b0, cmpl_flags};
                    mq[mdone] = t;
                    mdone++;
                end else begin
                    morph = 1;
                end
            end
            if (vld && rec_ready) begin
                void'(mq.pop_front());
                mdone--;
            end
            if (issue_valid && rdy) begin
                t.op = issue_op; t.rm = issue_rm; t.en = issue_enable;
                t.a = issue_a; t.b = issue_b; t.c = issue_c; t.res = '0; t.exc = '0;
                mq.push_back(t);
                if (!(issue_op >= 1 && issue_op <= 13) || !(issue_rm inside {0, 1, 2, 3, 4, 6}))
                    mill = 1;
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_issue_ready", issue_ready, mq.size() < DEPTH);
        chk("rnd_rec_valid", rec_valid, mdone > 0);
        chk("rnd_err_orphan", err_orphan, morph);
`ifdef COVERFLOAT_LEGAL_CHECK_EN
        chk("rnd_err_illegal", err_illegal, mill);
`endif
        if (mdone > 0) begin
            chk("rnd_rec_op", rec_op, mq[0].op);
            chk("rnd_rec_rm", rec_rm, mq[0].rm);
            chk("rnd_rec_enable", rec_enable, mq[0].en);
            chk("rnd_rec_a", rec_a, mq[0].a);
            chk("rnd_rec_b", rec_b, mq[0].b);
            chk("rnd_rec_c", rec_c, mq[0].c);
            chk("rnd_rec_result", rec_result, mq[0].res);
            chk("rnd_rec_exc", rec_exc, mq[0].exc);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk("reset_issue_ready", issue_ready, 1);
        chk("reset_rec_valid", rec_valid, 0);
        chk("reset_err_orphan", err_orphan, 0);

        tbl[0]  = mk(1, 1, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 32'h40400000, 0, 0, 1, 1, 0, 1, 32'h40400000, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 2, 32'h11, 32'h12, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 3, 32'h21, 32'h22, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 32'h11111111, 5'b00001, 0, 1, 1, 0, 2, 32'h11111111, 1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 32'h22222222, 5'b10000, 0, 1, 1, 0, 2, 32'h11111111, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 3, 32'h22222222, 16);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 32'hA4, 0, 0, 0, 1, 0, 4, 32'hA4, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 32'hA5, 0, 0, 0, 1, 0, 4, 32'hA4, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 32'hA6, 0, 0, 0, 1, 0, 4, 32'hA4, 0);
        tbl[16] = mk(0, 0, 0, 0, 1, 32'hA7, 0, 0, 0, 1, 0, 4, 32'hA4, 0);
        tbl[17] = mk(1, 9, 0, 0, 0, 0, 0, 1, 1, 1, 0, 5, 32'hA5, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6, 32'hA6, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 7, 32'hA7, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            idle();
            issue_valid = tbl[i].iv; issue_op = tbl[i].op;
            issue_a = tbl[i].a; issue_b = tbl[i].b;
            cmpl_valid = tbl[i].cv; cmpl_result = tbl[i].res; cmpl_flags = tbl[i].fl;
            rec_ready = tbl[i].rr;
            tick();
            chk($sformatf("tbl%0d_issue_ready", i), issue_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_rec_valid", i), rec_valid, tbl[i].e_rv);
            chk($sformatf("tbl%0d_err_orphan", i), err_orphan, tbl[i].e_orph);
            if (tbl[i].e_rv) begin
                chk($sformatf("tbl%0d_rec_op", i), rec_op, tbl[i].e_op);
                chk($sformatf("tbl%0d_rec_result", i), rec_result, tbl[i].e_res);
                chk($sformatf("tbl%0d_rec_exc", i), rec_exc, tbl[i].e_exc);
            end
        end
        idle();
        tick();
        chk("orphan_sticky", err_orphan, 1);
        chk("orphan_no_rec", rec_valid, 0);

        // reset with entries pending and one done, colliding with issue/cmpl/pop
        do_reset();
        chk("rst2_err_orphan", err_orphan, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            issue_valid = 1'b1; issue_op = 32'(i + 1);
            tick();
        end
        idle();
        cmpl_valid = 1'b1; cmpl_result = 32'h55;
        tick();
        chk("pre_rst_rec_valid", rec_valid, 1);
        idle();
        reset = 1'b1; issue_valid = 1'b1; issue_op = 32'd8; cmpl_valid = 1'b1; rec_ready = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("midrst_rec_valid", rec_valid, 0);
        chk("midrst_issue_ready", issue_ready, 1);
        chk("midrst_err_orphan", err_orphan, 0);
        cmpl_valid = 1'b1;
        tick();
        idle();
        chk("postrst_err_orphan", err_orphan, 1);
        chk("postrst_rec_valid", rec_valid, 0);

`ifdef COVERFLOAT_LEGAL_CHECK_EN
        do_reset();
        chk("legal_reset", err_illegal, 0);
        issue_valid = 1'b1; issue_op = 32'd14; issue_rm = 32'd5;
        tick();
        idle();
        chk("illegal_set", err_illegal, 1);
        cmpl_valid = 1'b1; cmpl_result = 32'h7FC00000; cmpl_flags = 5'b10000;
        tick();
        idle();
        chk("illegal_rec_valid", rec_valid, 1);
        chk("illegal_rec_op", rec_op, 14);
        chk("illegal_rec_rm", rec_rm, 5);
        rec_ready = 1'b1;
        tick();
        idle();
        chk("illegal_popped", rec_valid, 0);
`endif

        // randomized run against the queue model
        do_reset();
        mq.delete(); mdone = 0; morph = 0; mill = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            model_check();
            reset        = ($urandom_range(0, 299) == 0);
            issue_valid  = ($urandom_range(0, 2) != 0);
            issue_op     = $urandom_range(0, 15);
            issue_rm     = $urandom_range(0, 7);
            issue_enable = $urandom;
            issue_a      = $urandom;
            issue_b      = $urandom;
            issue_c      = $urandom;
            if (mq.size() > mdone) cmpl_valid = ($urandom_range(0, 1) != 0);
            else                   cmpl_valid = ($urandom_range(0, 49) == 0);
            cmpl_result  = $urandom;
            cmpl_flags   = 5'($urandom);
            rec_ready    = ($urandom_range(0, 3) != 0);
            model_update();
            tick();
        end
        reset = 1'b0;
        idle();
        model_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
